// File: rtl/ras_ckpt.sv
//------------------------------------------------------------------------------
// Module   : ras_ckpt
// Brief    : Checkpointable return-address stack for fetch prediction.
//            Optional per-entry repeat counters enabled by RAS_RPT_CNT_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ras_ckpt #(
  parameter int RAS_ENTRIES = 16,
  parameter int PC_WIDTH    = 38,
  parameter int RPT_WIDTH   = 2,
  localparam int LOG_E      = $clog2(RAS_ENTRIES)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                fetch_valid,
  input  logic                fetch_push,
  input  logic                fetch_pop,
  input  logic [PC_WIDTH-1:0] fetch_push_pc,
  output logic [PC_WIDTH-1:0] fetch_ret_pc,
  output logic [LOG_E-1:0]    fetch_ras_idx,
  output logic [LOG_E:0]      fetch_ras_count,
  output logic                fetch_ras_empty,
  input  logic                update_valid,
  input  logic [LOG_E-1:0]    update_ras_idx,
  input  logic [LOG_E:0]      update_ras_count,
  input  logic                update_write_top,
  input  logic [PC_WIDTH-1:0] update_top_pc
`ifdef RAS_RPT_CNT_EN
  ,
  output logic [RPT_WIDTH-1:0] fetch_ras_rpt,
  input  logic [RPT_WIDTH-1:0] update_ras_rpt
`endif
);

  localparam logic [LOG_E:0] C_FULL = (LOG_E+1)'(RAS_ENTRIES);

  logic [LOG_E-1:0]    ptr_q,   ptr_d;
  logic [LOG_E:0]      count_q, count_d;
  logic [PC_WIDTH-1:0] entries_q [RAS_ENTRIES];
  logic [PC_WIDTH-1:0] entries_d [RAS_ENTRIES];

  logic [LOG_E-1:0] w_ptr_inc;
  logic [LOG_E-1:0] w_ptr_dec;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_push_pop;

  assign w_ptr_inc   = ptr_q + 1'b1;
  assign w_ptr_dec   = ptr_q - 1'b1;
  assign w_push_only = fetch_valid &  fetch_push & ~fetch_pop;
  assign w_pop_only  = fetch_valid & ~fetch_push &  fetch_pop;
  assign w_push_pop  = fetch_valid &  fetch_push &  fetch_pop;

`ifdef RAS_RPT_CNT_EN
  localparam logic [RPT_WIDTH-1:0] C_RPT_MAX = '1;

  logic [RPT_WIDTH-1:0] rpt_q [RAS_ENTRIES];
  logic [RPT_WIDTH-1:0] rpt_d [RAS_ENTRIES];
  logic                 w_rpt_hit;
  logic                 w_rpt_nz;

  // A repeated push of the current top collapses into its counter (recursion).
  assign w_rpt_hit = (count_q != '0) && (fetch_push_pc == entries_q[ptr_q])
                     && (rpt_q[ptr_q] != C_RPT_MAX);
  assign w_rpt_nz  = (rpt_q[ptr_q] != '0);
`else
  logic w_rpt_hit;
  logic w_rpt_nz;

  assign w_rpt_hit = 1'b0;
  assign w_rpt_nz  = 1'b0;
`endif

  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    entries_d = entries_q;
`ifdef RAS_RPT_CNT_EN
    rpt_d     = rpt_q;
`endif
    // A restore wins over the fetch op issued in the same cycle.
    if (update_valid) begin
      ptr_d   = update_ras_idx;
      count_d = update_ras_count;
      if (update_write_top) begin
        entries_d[update_ras_idx] = update_top_pc;
      end
`ifdef RAS_RPT_CNT_EN
      rpt_d[update_ras_idx] = update_ras_rpt;
`endif
    end else if (w_push_pop) begin
      entries_d[ptr_q] = fetch_push_pc;
`ifdef RAS_RPT_CNT_EN
      rpt_d[ptr_q] = '0;
`endif
    end else if (w_push_only) begin
      if (w_rpt_hit) begin
`ifdef RAS_RPT_CNT_EN
        rpt_d[ptr_q] = rpt_q[ptr_q] + 1'b1;
`endif
      end else begin
        ptr_d                = w_ptr_inc;
        entries_d[w_ptr_inc] = fetch_push_pc;
        count_d              = (count_q == C_FULL) ? count_q : count_q + 1'b1;
`ifdef RAS_RPT_CNT_EN
        rpt_d[w_ptr_inc] = '0;
`endif
      end
    end else if (w_pop_only) begin
      if (w_rpt_nz) begin
`ifdef RAS_RPT_CNT_EN
        rpt_d[ptr_q] = rpt_q[ptr_q] - 1'b1;
`endif
      end else begin
        // Underflow still walks the pointer so later restores stay aligned.
        ptr_d   = w_ptr_dec;
        count_d = (count_q == '0) ? count_q : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

`ifdef RAS_RPT_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        rpt_q[i] <= '0;
      end
    end else begin
      rpt_q <= rpt_d;
    end
  end

  assign fetch_ras_rpt = rpt_q[ptr_q];
`endif

  assign fetch_ret_pc    = entries_q[ptr_q];
  assign fetch_ras_idx   = ptr_q;
  assign fetch_ras_count = count_q;
  assign fetch_ras_empty = (count_q == '0);

  a_restore_count_legal : assert property (
    @(posedge CLK) disable iff (RST) update_valid |-> (update_ras_count <= C_FULL)
  );

endmodule

`default_nettype wire

// File: tb/tb_ras_ckpt.sv
//------------------------------------------------------------------------------
// Module   : tb_ras_ckpt
// Brief    : Directed-vector bench for ras_ckpt (repeat-counter vectors need
//            RAS_RPT_CNT_EN).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ras_ckpt;

  localparam int E  = 16;
  localparam int PW = 38;
  localparam int LE = 4;
  localparam int RW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          fetch_valid, fetch_push, fetch_pop;
  logic [PW-1:0] fetch_push_pc;
  logic [PW-1:0] fetch_ret_pc;
  logic [LE-1:0] fetch_ras_idx;
  logic [LE:0]   fetch_ras_count;
  logic          fetch_ras_empty;
  logic          update_valid, update_write_top;
  logic [LE-1:0] update_ras_idx;
  logic [LE:0]   update_ras_count;
  logic [PW-1:0] update_top_pc;
`ifdef RAS_RPT_CNT_EN
  logic [RW-1:0] fetch_ras_rpt;
  logic [RW-1:0] update_ras_rpt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ras_ckpt #(.RAS_ENTRIES(E), .PC_WIDTH(PW), .RPT_WIDTH(RW)) u_dut (
    .CLK              (CLK),
    .RST              (RST),
    .fetch_valid      (fetch_valid),
    .fetch_push       (fetch_push),
    .fetch_pop        (fetch_pop),
    .fetch_push_pc    (fetch_push_pc),
    .fetch_ret_pc     (fetch_ret_pc),
    .fetch_ras_idx    (fetch_ras_idx),
    .fetch_ras_count  (fetch_ras_count),
    .fetch_ras_empty  (fetch_ras_empty),
    .update_valid     (update_valid),
    .update_ras_idx   (update_ras_idx),
    .update_ras_count (update_ras_count),
    .update_write_top (update_write_top),
    .update_top_pc    (update_top_pc)
`ifdef RAS_RPT_CNT_EN
    ,
    .fetch_ras_rpt    (fetch_ras_rpt),
    .update_ras_rpt   (update_ras_rpt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are read there too.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    fetch_valid      = 1'b0;
    fetch_push       = 1'b0;
    fetch_pop        = 1'b0;
    fetch_push_pc    = '0;
    update_valid     = 1'b0;
    update_write_top = 1'b0;
    update_ras_idx   = '0;
    update_ras_count = '0;
    update_top_pc    = '0;
`ifdef RAS_RPT_CNT_EN
    update_ras_rpt   = '0;
`endif
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
  endtask

  task automatic op(input logic psh, input logic pp, input logic [PW-1:0] pc);
    fetch_valid   = 1'b1;
    fetch_push    = psh;
    fetch_pop     = pp;
    fetch_push_pc = pc;
    cyc();
    idle();
  endtask

  task automatic chk_state(input string tag, input logic [PW-1:0] ret,
                           input int idx, input int cnt);
    chk({tag, ".ret"},   64'(fetch_ret_pc),    64'(ret));
    chk({tag, ".idx"},   64'(fetch_ras_idx),   64'(idx));
    chk({tag, ".count"}, 64'(fetch_ras_count), 64'(cnt));
    chk({tag, ".empty"}, 64'(fetch_ras_empty), 64'(cnt == 0));
  endtask

  initial begin
    idle();
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
    chk_state("rst", '0, 0, 0);

    // Basic push/push/pop
    op(1'b1, 1'b0, 38'h100);
    op(1'b1, 1'b0, 38'h200);
    chk_state("t1.push2", 38'h200, 2, 2);
    op(1'b0, 1'b1, '0);
    chk_state("t1.pop", 38'h100, 1, 1);

    // Overflow then drain past empty
    do_reset();
    for (int i = 0; i <= E; i++) op(1'b1, 1'b0, 38'(32'h1000 + i * 16));
    chk_state("t2.full", 38'(32'h1000 + E * 16), 1, E);
    for (int k = 0; k < E; k++) begin
      chk("t2.drain.ret", 64'(fetch_ret_pc), 64'(32'h1000 + (E - k) * 16));
      op(1'b0, 1'b1, '0);
    end
    chk("t2.drained.count", 64'(fetch_ras_count), 64'd0);
    chk("t2.drained.empty", 64'(fetch_ras_empty), 64'd1);
    chk("t2.drained.idx",   64'(fetch_ras_idx),   64'd1);
    op(1'b0, 1'b1, '0);
    chk("t2.under.count", 64'(fetch_ras_count), 64'd0);
    chk("t2.under.empty", 64'(fetch_ras_empty), 64'd1);
    chk("t2.under.idx",   64'(fetch_ras_idx),   64'd0);

    // Simultaneous push+pop replaces top in place
    do_reset();
    op(1'b1, 1'b0, 38'h100);
    op(1'b1, 1'b1, 38'h300);
    chk_state("t3.pushpop", 38'h300, 1, 1);

    // Restore with top write beats a concurrent push
    do_reset();
    op(1'b1, 1'b0, 38'h10);
    op(1'b1, 1'b0, 38'h20);
    op(1'b1, 1'b0, 38'h30);
    chk_state("t4.pre", 38'h30, 3, 3);
    update_valid     = 1'b1;
    update_ras_idx   = 4'd1;
    update_ras_count = 5'd1;
    update_write_top = 1'b1;
    update_top_pc    = 38'hABC;
    fetch_valid      = 1'b1;
    fetch_push       = 1'b1;
    fetch_push_pc    = 38'hDEF;
    cyc();
    idle();
    chk_state("t4.restore", 38'hABC, 1, 1);
    op(1'b0, 1'b1, '0);
    chk_state("t4.pop", '0, 0, 0);

    // Restore without top write keeps array contents
    op(1'b1, 1'b0, 38'h55);
    update_valid     = 1'b1;
    update_ras_idx   = 4'd3;
    update_ras_count = 5'd3;
    cyc();
    idle();
    chk_state("t4b.restore", 38'h30, 3, 3);

    // Reset during restore leaves no trace
    update_valid     = 1'b1;
    update_ras_idx   = 4'd7;
    update_ras_count = 5'd5;
    update_write_top = 1'b1;
    update_top_pc    = 38'h777;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    idle();
    chk_state("t5.rst", '0, 0, 0);
    cyc();
    chk_state("t5.after", '0, 0, 0);

`ifdef RAS_RPT_CNT_EN
    do_reset();
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 38'h4444);
    chk_state("t6.rep4", 38'h4444, 1, 1);
    chk("t6.rep4.rpt", 64'(fetch_ras_rpt), 64'd3);
    op(1'b1, 1'b0, 38'h4444);
    chk_state("t6.rep5", 38'h4444, 2, 2);
    chk("t6.rep5.rpt", 64'(fetch_ras_rpt), 64'd0);
    op(1'b0, 1'b1, '0);
    chk_state("t6.pop1", 38'h4444, 1, 1);
    for (int k = 2; k >= 0; k--) begin
      op(1'b0, 1'b1, '0);
      chk("t6.popdec.rpt",   64'(fetch_ras_rpt),   64'(k));
      chk("t6.popdec.count", 64'(fetch_ras_count), 64'd1);
    end
    op(1'b0, 1'b1, '0);
    chk_state("t6.empty", '0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
